// File: rtl/clk_div_sequencer_pkg.sv
// Shared types and helpers for the divided-clock sequencer.
package clk_div_sequencer_pkg;

  // Run/stop controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Widest half-period value the clamp helper accepts.
  localparam int unsigned HALF_PERIOD_MAX_WIDTH = 32;

  // A half-period of zero has no meaning; treat it as the shortest legal value.
  function automatic logic [HALF_PERIOD_MAX_WIDTH-1:0] clamp_nonzero(
    input logic [HALF_PERIOD_MAX_WIDTH-1:0] value
  );
    return (value == '0) ? HALF_PERIOD_MAX_WIDTH'(1) : value;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter, clk_out toggle and tick generator.
// run=1 counts; run=0 holds counter and clk_out cleared.
module clk_div_core #(
  parameter int BIT_LENGTH_OF_HALF_PERIOD = 8
) (
  input  logic                                 clk_in,
  input  logic                                 rst_n,
  input  logic                                 run,
  input  logic [BIT_LENGTH_OF_HALF_PERIOD-1:0] half_period,
  output logic                                 clk_out,
  output logic                                 tick,
  output logic                                 at_fall
);

  logic [BIT_LENGTH_OF_HALF_PERIOD-1:0] counter;
  logic                                 terminal;

  // half_period is always >= 1, so the subtraction cannot wrap.
  assign terminal = (counter == half_period - BIT_LENGTH_OF_HALF_PERIOD'(1));
  // Next counting edge is a 1->0 toggle (only meaningful while run=1).
  assign at_fall  = terminal && clk_out;

  // Count the half-period and toggle clk_out at its last cycle.
  always_ff @(posedge clk_in or negedge rst_n) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      counter <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (!run) begin
      counter <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (terminal) begin
      counter <= '0;
      clk_out <= ~clk_out;
      tick    <= 1'b1;
    end else begin
      counter <= counter + BIT_LENGTH_OF_HALF_PERIOD'(1);
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_sequencer.sv
// Run/stop FSM plus one-deep half-period reconfiguration for the divided clock.
// New values are applied only in IDLE or at a 1->0 toggle, so no runt pulses.
module clk_div_sequencer
  import clk_div_sequencer_pkg::*;
#(
  parameter int BIT_LENGTH_OF_HALF_PERIOD = 8,
  parameter int HALF_PERIOD               = 7
) (
  input  logic                                 clk_in,
  input  logic                                 rst_n,
  input  logic                                 enable,
  input  logic                                 cfg_valid,
  input  logic [BIT_LENGTH_OF_HALF_PERIOD-1:0] cfg_half_period,
  output logic                                 cfg_ready,
  output logic                                 clk_out,
  output logic                                 tick,
  output logic [BIT_LENGTH_OF_HALF_PERIOD-1:0] active_half_period,
  output logic                                 busy
);

  localparam int W = BIT_LENGTH_OF_HALF_PERIOD;

  state_e         state, state_next;
  logic           pending;
  logic [W-1:0]   pending_value;
  logic           core_run;
  logic           core_at_fall;
  logic           fall_now;
  logic           capture;
  logic           apply;

  // Stopping with clk_out low is immediate; otherwise the high phase drains.
  assign core_run  = (state == RUN || state == DRAIN) &&
                     !(state == RUN && !enable && !clk_out);
  assign fall_now  = core_run && core_at_fall;

  assign cfg_ready = !pending;
  assign capture   = cfg_valid && !pending;
  // capture needs pending=0 and apply needs pending=1, so they never coincide.
  assign apply     = pending && (state == IDLE || fall_now);
  assign busy      = (state != IDLE) || pending;

  clk_div_core #(
    .BIT_LENGTH_OF_HALF_PERIOD(W)
  ) u_core (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .run         (core_run),
    .half_period (active_half_period),
    .clk_out     (clk_out),
    .tick        (tick),
    .at_fall     (core_at_fall)
  );

  // State register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic for run, drain and stop.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (!enable) begin
                 if (!clk_out || fall_now) state_next = IDLE;
                 else                      state_next = DRAIN;
               end
      DRAIN:   if (fall_now) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One-entry config holding register and the active half-period.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pending            <= 1'b0;
      pending_value      <= W'(HALF_PERIOD);
      active_half_period <= W'(HALF_PERIOD);
    end else if (capture) begin
      pending       <= 1'b1;
      pending_value <= W'(clamp_nonzero(HALF_PERIOD_MAX_WIDTH'(cfg_half_period)));
    end else if (apply) begin
      pending            <= 1'b0;
      active_half_period <= pending_value;
    end
  end

endmodule
